csc_column_walker: RTL and testbench

Downstream consumer of the odd-address pointer counter in the column-wise sparse-dense multiplier. Given the pointer-memory address of a CSC column (start pointer at `col_addr`, end pointer at `col_addr+1`), it reads both pointers, then walks every nonzero of that column. It fetches value and row index from synchronous memories and streams (value, row) pairs to the MAC stage over a valid/ready handshake. On completion it pulses `next_col`, which drives the pointer counter's `enable`.

---
 rtl/csc_column_walker.sv | 119 +++++++++++
 tb/tb_csc_column_walker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_column_walker.sv
// rtl/csc_column_walker.sv - walks one CSC column: reads begin/end pointers, then streams (value, row) pairs.
// Pulses next_col on completion to advance the upstream pointer counter.
module csc_column_walker #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16,
   parameter int IDX_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] col_addr,
   output logic [ADDR_W-1:0] ptr_rd_addr,
   input  logic [ADDR_W-1:0] ptr_rd_data,
   output logic [ADDR_W-1:0] nz_rd_addr,
   input  logic [DATA_W-1:0] val_rd_data,
   input  logic [IDX_W-1:0]  row_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_val,
   output logic [IDX_W-1:0]  out_row,
   output logic              out_last,
   output logic              busy,
   output logic              next_col
);

   typedef enum logic [2:0] {
      IDLE, PTR0, PTR1, PTR2, NZ_RD, NZ_CAP, OUT, DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t            state;
   logic [ADDR_W-1:0] col_q;
   logic [ADDR_W-1:0] begin_ptr;
   logic [ADDR_W-1:0] end_ptr;
   logic [ADDR_W-1:0] nz_next;

   assign nz_next = nz_rd_addr + ONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         col_q       <= '0;
         begin_ptr   <= '0;
         end_ptr     <= '0;
         ptr_rd_addr <= '0;
         nz_rd_addr  <= '0;
         out_valid   <= 1'b0;
         out_val     <= '0;
         out_row     <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         next_col    <= 1'b0;
      end else begin
         next_col <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (start) begin
                  col_q       <= col_addr;
                  ptr_rd_addr <= col_addr;
                  busy        <= 1'b1;
                  state       <= PTR0;
               end
            end
            PTR0: begin
               ptr_rd_addr <= col_q + ONE;
               state       <= PTR1;
            end
            PTR1: begin
               begin_ptr <= ptr_rd_data;
               state     <= PTR2;
            end
            PTR2: begin
               end_ptr <= ptr_rd_data;
               // end <= begin covers both empty and corrupt columns
               if (ptr_rd_data <= begin_ptr) begin
                  next_col <= 1'b1;
                  state    <= DONE;
               end else begin
                  nz_rd_addr <= begin_ptr;
                  state      <= NZ_RD;
               end
            end
            NZ_RD: begin
               state <= NZ_CAP;
            end
            NZ_CAP: begin
               out_val   <= val_rd_data;
               out_row   <= row_rd_data;
               out_last  <= (nz_next == end_ptr);
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     next_col <= 1'b1;
                     state    <= DONE;
                  end else begin
                     nz_rd_addr <= nz_next;
                     state      <= NZ_RD;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csc_column_walker.sv
// tb/tb_csc_column_walker.sv - randomized self-checking bench for csc_column_walker.
// Expected pairs come from the CSC pointer/value arrays; a monitor scores every handshake.
module tb_csc_column_walker;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 16;
   localparam int IDX_W  = 10;

   typedef struct packed {
      logic [DATA_W-1:0] v;
      logic [IDX_W-1:0]  r;
      logic              l;
   } pair_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] col_addr = '0;
   logic [ADDR_W-1:0] ptr_rd_addr;
   logic [ADDR_W-1:0] ptr_rd_data = '0;
   logic [ADDR_W-1:0] nz_rd_addr;
   logic [DATA_W-1:0] val_rd_data = '0;
   logic [IDX_W-1:0]  row_rd_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_val;
   logic [IDX_W-1:0]  out_row;
   logic              out_last;
   logic              busy;
   logic              next_col;

   csc_column_walker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset), .start(start), .col_addr(col_addr),
      .ptr_rd_addr(ptr_rd_addr), .ptr_rd_data(ptr_rd_data),
      .nz_rd_addr(nz_rd_addr), .val_rd_data(val_rd_data), .row_rd_data(row_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
      .out_row(out_row), .out_last(out_last), .busy(busy), .next_col(next_col)
   );

   always #5 clk = ~clk;

   logic [ADDR_W-1:0] ptr_mem [2048];
   logic [DATA_W-1:0] val_mem [2048];
   logic [IDX_W-1:0]  row_mem [2048];

   always @(posedge clk) begin
      ptr_rd_data <= ptr_mem[ptr_rd_addr];
      val_rd_data <= val_mem[nz_rd_addr];
      row_rd_data <= row_mem[nz_rd_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    errors = 0;
   int    checks = 0;
   pair_t exp_q[$];
   pair_t got_q[$];
   int    nc_count = 0;
   int    accepted = 0;
   int    first_rise = -1;
   int    last_hs = -1;
   int    nc_cyc = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: scores every accepted pair, hold stability while stalled, spacing and next_col
   initial begin
      logic  pv;
      logic  pr;
      pair_t pp;
      pair_t cur;
      pair_t e;
      pv = 1'b0;
      pr = 1'b0;
      pp = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pv = 1'b0;
            pr = 1'b0;
         end else begin
            cur = {out_val, out_row, out_last};
            if (out_valid && !pv) begin
               if (first_rise < 0) first_rise = cyc;
               else check("pair spacing", 64'(cyc - last_hs), 64'd3);
            end
            if (out_valid && pv && !pr) check("hold while stalled", 64'(cur), 64'(pp));
            if (out_valid && out_ready) begin
               accepted++;
               last_hs = cyc;
               got_q.push_back(cur);
               if (exp_q.size() == 0) begin
                  check("unexpected pair", 64'(cur), 64'hdead);
               end else begin
                  e = exp_q.pop_front();
                  check("pair", 64'(cur), 64'(e));
               end
            end
            if (next_col) begin
               nc_count++;
               nc_cyc = cyc;
               check("pairs left at next_col", 64'(exp_q.size()), 64'd0);
            end
            pv = out_valid;
            pr = out_ready;
            pp = cur;
         end
      end
   end

   task automatic build_exp(input logic [ADDR_W-1:0] a, output int n);
      logic [ADDR_W-1:0] b;
      logic [ADDR_W-1:0] en;
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] idx;
      pair_t             p;
      a1 = a + 11'd1;
      b  = ptr_mem[a];
      en = ptr_mem[a1];
      n  = (en > b) ? int'(en) - int'(b) : 0;
      for (int i = 0; i < n; i++) begin
         idx = b + 11'(i);
         p.v = val_mem[idx];
         p.r = row_mem[idx];
         p.l = (i == n - 1);
         exp_q.push_back(p);
      end
   endtask

   // mode: 0 ready high, 1 random ready, 2 stall second pair 5 cycles, 3 spurious start
   task automatic run_column(input logic [ADDR_W-1:0] a, input int mode);
      int n, nc0, acc0, e0, stall;
      bit done, inj;
      build_exp(a, n);
      nc0 = nc_count;
      acc0 = accepted;
      first_rise = -1;
      stall = 0;
      inj = 1'b0;
      done = 1'b0;
      @(posedge clk);
      #1 start = 1'b1;
      col_addr = a;
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1 e0 = cyc;
      start = 1'b0;
      check("busy after start", 64'(busy), 64'd1);
      for (int c = 0; c < 500 && !done; c++) begin
         @(negedge clk);
         if (next_col) begin
            done = 1'b1;
            start = 1'b0;
         end else begin
            @(posedge clk);
            #1;
            case (mode)
               1: out_ready = ($urandom_range(0, 3) != 0);
               2: begin
                  if (out_valid && (accepted - acc0 == 1) && stall < 5) begin
                     out_ready = 1'b0;
                     stall++;
                  end else out_ready = 1'b1;
               end
               3: begin
                  out_ready = 1'b1;
                  if (out_valid && !inj) begin
                     start = 1'b1;
                     col_addr = 11'd3;
                     inj = 1'b1;
                  end else start = 1'b0;
               end
               default: out_ready = 1'b1;
            endcase
         end
      end
      if (!done) begin
         check("column timeout", 64'd0, 64'd1);
         exp_q.delete();
         return;
      end
      check("one next_col", 64'(nc_count - nc0), 64'd1);
      check("pair count", 64'(accepted - acc0), 64'(n));
      if (n > 0) begin
         check("first pair latency", 64'(first_rise - e0), 64'd5);
         check("next_col after last handshake", 64'(nc_cyc - last_hs), 64'd1);
      end else begin
         check("empty column next_col timing", 64'(nc_cyc - e0), 64'd3);
      end
      @(posedge clk);
      #1 check("idle after done", 64'({busy, out_valid, next_col}), 64'd0);
   endtask

   initial begin
      int n, nc0, acc0, g0;
      bit found;
      for (int i = 0; i < 2048; i++) begin
         ptr_mem[i] = 11'($urandom);
         val_mem[i] = 16'($urandom);
         row_mem[i] = 10'($urandom);
      end
      ptr_mem[1] = 11'd4;  ptr_mem[2] = 11'd7;
      ptr_mem[3] = 11'd5;  ptr_mem[4] = 11'd5;
      ptr_mem[5] = 11'd9;  ptr_mem[6] = 11'd6;
      val_mem[4] = 16'd10; val_mem[5] = 16'd20; val_mem[6] = 16'd30;
      row_mem[4] = 10'd3;  row_mem[5] = 10'd8;  row_mem[6] = 10'd9;
      ptr_mem[2047] = 11'd20;
      ptr_mem[0]    = 11'd22;
      ptr_mem[200]  = 11'd600;
      for (int k = 1; k <= 40; k++) begin
         if ($urandom_range(0, 7) == 0)
            ptr_mem[200 + k] = ptr_mem[199 + k] - 11'($urandom_range(1, 4));
         else
            ptr_mem[200 + k] = ptr_mem[199 + k] + 11'($urandom_range(0, 5));
      end

      #2 check("reset outputs", 64'({ptr_rd_addr, nz_rd_addr, out_valid, out_val, out_row,
                                     out_last, busy, next_col}), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      run_column(11'd1, 0);
      g0 = got_q.size() - 3;
      check("column1 pair0", 64'(got_q[g0]),     64'({16'd10, 10'd3, 1'b0}));
      check("column1 pair1", 64'(got_q[g0 + 1]), 64'({16'd20, 10'd8, 1'b0}));
      check("column1 pair2", 64'(got_q[g0 + 2]), 64'({16'd30, 10'd9, 1'b1}));

      run_column(11'd3, 0);
      run_column(11'd5, 0);
      run_column(11'd1, 2);
      run_column(11'd1, 3);

      // Reset while the second pair of column 1 is being offered
      build_exp(11'd1, n);
      acc0 = accepted;
      first_rise = -1;
      @(posedge clk);
      #1 start = 1'b1;
      col_addr = 11'd1;
      out_ready = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (out_valid && (accepted - acc0 == 1)) found = 1'b1;
         else out_ready = (accepted - acc0 == 0);
      end
      check("reached second pair", 64'(found), 64'd1);
      #2 reset = 1'b1;
      #1 check("reset drops outputs", 64'({out_valid, busy, next_col}), 64'd0);
      exp_q.delete();
      nc0 = nc_count;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("no next_col from reset", 64'(nc_count - nc0), 64'd0);
      g0 = got_q.size();
      run_column(11'd1, 0);
      check("restart pair0", 64'(got_q[g0]), 64'({16'd10, 10'd3, 1'b0}));

      run_column(11'd2047, 1);

      for (int t = 0; t < 30; t++)
         run_column(11'(200 + $urandom_range(0, 39)), int'($urandom_range(0, 1)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
